// File: rtl/l2cache_tag_lookup.sv
// L2 tag lookup: compares a set's way tags against a request tag and picks the victim way.
// Two-stage pipeline (S1 request regs, S2 response regs) with tree-PLRU update and hit/miss counters.
module l2cache_tag_lookup #(
  parameter int unsigned WAYS   = 8,
  parameter int unsigned TAG_W  = 19,
  parameter int unsigned CNT_W  = 32,
  localparam int unsigned WAY_W  = $clog2(WAYS),
  localparam int unsigned PLRU_W = WAYS - 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [TAG_W-1:0]      req_tag,
  input  logic [WAYS*TAG_W-1:0] req_way_tags,
  input  logic [WAYS-1:0]       req_v,
  input  logic [WAYS-1:0]       req_d,
  input  logic [PLRU_W-1:0]     req_plru,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_hit,
  output logic                  rsp_multi_hit,
  output logic [WAY_W-1:0]      rsp_hit_way,
  output logic                  rsp_have_empty,
  output logic [WAY_W-1:0]      rsp_victim_way,
  output logic                  rsp_need_wb,
  output logic [PLRU_W-1:0]     rsp_plru_next,
  input  logic                  perf_clr,
  output logic [CNT_W-1:0]      perf_hit_cnt,
  output logic [CNT_W-1:0]      perf_miss_cnt
);

  // S1 request registers
  logic                  s1Valid;
  logic [TAG_W-1:0]      s1Tag;
  logic [WAYS*TAG_W-1:0] s1WayTags;
  logic [WAYS-1:0]       s1V;
  logic [WAYS-1:0]       s1D;
  logic [PLRU_W-1:0]     s1Plru;

  logic s2Advance;
  logic s1Move;
  logic reqFire;
  logic rspFire;

  assign s2Advance = !rsp_valid || rsp_ready;
  assign s1Move    = s1Valid && s2Advance;
  // rst_n gates ready so nothing is accepted while reset is held
  assign req_ready = rst_n && (!s1Valid || s2Advance);
  assign reqFire   = req_valid && req_ready;
  assign rspFire   = rsp_valid && rsp_ready;

  // Compare logic between S1 and S2
  logic [WAYS-1:0]   hitVec;
  logic              hit;
  logic              multiHit;
  logic [WAY_W-1:0]  hitWay;
  logic              haveEmpty;
  logic [WAY_W-1:0]  emptyWay;
  logic [WAY_W-1:0]  evictWay;
  logic [WAY_W-1:0]  victimWay;
  logic              needWb;
  logic [PLRU_W-1:0] plruNext;

  always_comb begin
    for (int i = 0; i < WAYS; i++) begin
      hitVec[i] = s1V[i] && (s1WayTags[i*TAG_W +: TAG_W] == s1Tag);
    end
  end

  assign hit       = |hitVec;
  assign multiHit  = |(hitVec & (hitVec - WAYS'(1)));
  assign haveEmpty = !(&s1V);

  // Descending scan so the lowest index wins
  always_comb begin
    hitWay   = '0;
    emptyWay = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (hitVec[i]) hitWay = WAY_W'(i);
      if (!s1V[i])   emptyWay = WAY_W'(i);
    end
  end

  // Walk the heap-indexed tree from the root; a node bit of 1 selects the upper half
  always_comb begin
    int node;
    evictWay = '0;
    node     = 0;
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      evictWay[WAY_W-1-lvl] = s1Plru[node];
      node = 2 * node + 1 + int'(s1Plru[node]);
    end
  end

  always_comb begin
    if (hit) begin
      victimWay = hitWay;
    end else if (haveEmpty) begin
      victimWay = emptyWay;
    end else begin
      victimWay = evictWay;
    end
  end

  assign needWb = !hit && !haveEmpty && s1D[victimWay];

  // Point every node on the victim's path away from it
  always_comb begin
    int node;
    plruNext = s1Plru;
    node     = 0;
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      plruNext[node] = !victimWay[WAY_W-1-lvl];
      node = 2 * node + 1 + int'(victimWay[WAY_W-1-lvl]);
    end
  end

  // S1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid   <= 1'b0;
      s1Tag     <= '0;
      s1WayTags <= '0;
      s1V       <= '0;
      s1D       <= '0;
      s1Plru    <= '0;
    end else begin
      if (reqFire) begin
        s1Valid   <= 1'b1;
        s1Tag     <= req_tag;
        s1WayTags <= req_way_tags;
        s1V       <= req_v;
        s1D       <= req_d;
        s1Plru    <= req_plru;
      end else if (s1Move) begin
        s1Valid <= 1'b0;
      end
    end
  end

  // S2 response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid      <= 1'b0;
      rsp_hit        <= 1'b0;
      rsp_multi_hit  <= 1'b0;
      rsp_hit_way    <= '0;
      rsp_have_empty <= 1'b0;
      rsp_victim_way <= '0;
      rsp_need_wb    <= 1'b0;
      rsp_plru_next  <= '0;
    end else if (s2Advance) begin
      rsp_valid <= s1Valid;
      if (s1Valid) begin
        rsp_hit        <= hit;
        rsp_multi_hit  <= multiHit;
        rsp_hit_way    <= hitWay;
        rsp_have_empty <= haveEmpty;
        rsp_victim_way <= victimWay;
        rsp_need_wb    <= needWb;
        rsp_plru_next  <= plruNext;
      end
    end
  end

  // Saturating counters; clear wins over a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_hit_cnt  <= '0;
      perf_miss_cnt <= '0;
    end else if (perf_clr) begin
      perf_hit_cnt  <= '0;
      perf_miss_cnt <= '0;
    end else if (rspFire) begin
      if (rsp_hit && !(&perf_hit_cnt)) begin
        perf_hit_cnt <= perf_hit_cnt + CNT_W'(1);
      end
      if (!rsp_hit && !(&perf_miss_cnt)) begin
        perf_miss_cnt <= perf_miss_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_l2cache_tag_lookup.sv
// Scoreboard bench for l2cache_tag_lookup: the driver queues hand-computed responses on
// acceptance, and a negedge monitor compares every presented response against the queue head.
module tb_l2cache_tag_lookup;

  localparam int WAYS  = 8;
  localparam int TAG_W = 19;
  localparam int CNT_W = 32;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  req_valid;
  logic                  req_ready;
  logic [TAG_W-1:0]      req_tag;
  logic [WAYS*TAG_W-1:0] req_way_tags;
  logic [WAYS-1:0]       req_v;
  logic [WAYS-1:0]       req_d;
  logic [WAYS-2:0]       req_plru;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_hit;
  logic                  rsp_multi_hit;
  logic [2:0]            rsp_hit_way;
  logic                  rsp_have_empty;
  logic [2:0]            rsp_victim_way;
  logic                  rsp_need_wb;
  logic [6:0]            rsp_plru_next;
  logic                  perf_clr;
  logic [CNT_W-1:0]      perf_hit_cnt;
  logic [CNT_W-1:0]      perf_miss_cnt;

  l2cache_tag_lookup #(
    .WAYS (WAYS),
    .TAG_W(TAG_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_tag       (req_tag),
    .req_way_tags  (req_way_tags),
    .req_v         (req_v),
    .req_d         (req_d),
    .req_plru      (req_plru),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_hit       (rsp_hit),
    .rsp_multi_hit (rsp_multi_hit),
    .rsp_hit_way   (rsp_hit_way),
    .rsp_have_empty(rsp_have_empty),
    .rsp_victim_way(rsp_victim_way),
    .rsp_need_wb   (rsp_need_wb),
    .rsp_plru_next (rsp_plru_next),
    .perf_clr      (perf_clr),
    .perf_hit_cnt  (perf_hit_cnt),
    .perf_miss_cnt (perf_miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       hit;
    logic       multi;
    logic [2:0] hitWay;
    logic       haveEmpty;
    logic [2:0] victim;
    logic       needWb;
    logic [6:0] plru;
  } rspT;

  rspT sb[$];
  rspT actRsp;
  int  nCmp = 0;
  int  nBad = 0;
  int  accCnt = 0;
  int  rspIdx = 0;

  logic [WAYS*TAG_W-1:0] baseTags;
  logic [WAYS*TAG_W-1:0] dupTags;

  function automatic rspT mk(input logic hit, input logic multi, input logic [2:0] hw,
                             input logic he, input logic [2:0] vic, input logic wb,
                             input logic [6:0] pl);
    rspT r;
    r.hit = hit; r.multi = multi; r.hitWay = hw; r.haveEmpty = he;
    r.victim = vic; r.needWb = wb; r.plru = pl;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    nCmp++;
    if (got !== want) begin
      nBad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic sendReq(input logic [TAG_W-1:0] tag, input logic [WAYS*TAG_W-1:0] tags,
                         input logic [7:0] v, input logic [7:0] d, input logic [6:0] pl,
                         input rspT exp);
    logic rdy;
    logic got;
    req_tag = tag; req_way_tags = tags; req_v = v; req_d = d; req_plru = pl;
    req_valid = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      rdy = req_ready;
      @(posedge clk);
      #1;
      if (rdy) got = 1'b1;
    end
    req_valid = 1'b0;
    if (got) begin
      sb.push_back(exp);
      accCnt++;
    end else begin
      nCmp++;
      nBad++;
      $display("FAIL accept_timeout: got no accept want accept");
    end
  endtask

  task automatic drain();
    for (int c = 0; c < 50 && sb.size() != 0; c++) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  // Directed vectors; expected values worked by hand from the tree-PLRU rules
  task automatic vec1(); // hit way 5, dirty but no writeback
    sendReq(19'h105, baseTags, 8'hFF, 8'h20, 7'h00, mk(1, 0, 3'd5, 0, 3'd5, 0, 7'h04));
  endtask
  task automatic vec2(); // miss, lowest empty way 3
    sendReq(19'h7FFFF, baseTags, 8'hF7, 8'h00, 7'h00, mk(0, 0, 3'd0, 1, 3'd3, 0, 7'h01));
  endtask
  task automatic vec3(); // full miss, PLRU picks dirty way 3
    sendReq(19'h7FFFF, baseTags, 8'hFF, 8'h08, 7'h12, mk(0, 0, 3'd0, 0, 3'd3, 1, 7'h01));
  endtask
  task automatic vec4(); // multi-hit ways 1 and 6
    sendReq(19'h101, dupTags, 8'hFF, 8'h00, 7'h00, mk(1, 1, 3'd1, 0, 3'd1, 0, 7'h03));
  endtask
  task automatic vec5(); // way 1 invalid, so only way 6 hits
    sendReq(19'h101, dupTags, 8'hFD, 8'h00, 7'h00, mk(1, 0, 3'd6, 1, 3'd6, 0, 7'h40));
  endtask
  task automatic vec6(); // full miss, PLRU all ones -> way 7, dirty
    sendReq(19'h00000, baseTags, 8'hFF, 8'h80, 7'h7F, mk(0, 0, 3'd0, 0, 3'd7, 1, 7'h3A));
  endtask
  task automatic vec7(); // empty way 0 beats PLRU; dirty bits ignored
    sendReq(19'h00000, baseTags, 8'hFE, 8'hFF, 7'h7F, mk(0, 0, 3'd0, 1, 3'd0, 0, 7'h7F));
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      actRsp = {rsp_hit, rsp_multi_hit, rsp_hit_way, rsp_have_empty, rsp_victim_way,
                rsp_need_wb, rsp_plru_next};
      nCmp++;
      if (sb.size() == 0) begin
        nBad++;
        $display("FAIL unexpected_rsp: got %h want no response", actRsp);
      end else begin
        if (actRsp !== sb[0]) begin
          nBad++;
          $display("FAIL rsp%0d: got %h want %h", rspIdx, actRsp, sb[0]);
        end
        if (rsp_ready) begin
          void'(sb.pop_front());
          rspIdx++;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = 1'b0; req_tag = '0; req_way_tags = '0; req_v = '0; req_d = '0;
    req_plru = '0; rsp_ready = 1'b0; perf_clr = 1'b0;
    for (int i = 0; i < WAYS; i++) baseTags[i*TAG_W +: TAG_W] = 19'h100 + 19'(i);
    dupTags = baseTags;
    dupTags[6*TAG_W +: TAG_W] = 19'h101;

    #12;
    check("reset_req_ready", 64'(req_ready), 64'd0);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_rsp_fields", 64'({rsp_hit, rsp_multi_hit, rsp_hit_way, rsp_have_empty,
          rsp_victim_way, rsp_need_wb, rsp_plru_next}), 64'd0);
    check("reset_hit_cnt", 64'(perf_hit_cnt), 64'd0);
    check("reset_miss_cnt", 64'(perf_miss_cnt), 64'd0);
    #10;
    rst_n = 1'b1;
    #1;
    check("ready_after_release", 64'(req_ready), 64'd1);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;

    vec1();
    drain();
    check("hit_cnt_1", 64'(perf_hit_cnt), 64'd1);
    check("miss_cnt_0", 64'(perf_miss_cnt), 64'd0);
    vec2();
    drain();
    check("miss_cnt_1", 64'(perf_miss_cnt), 64'd1);
    vec3(); vec4(); vec5(); vec6(); vec7();
    drain();
    check("hit_cnt_3", 64'(perf_hit_cnt), 64'd3);
    check("miss_cnt_4", 64'(perf_miss_cnt), 64'd4);

    // Clear held across a response handshake must win over the increment
    perf_clr = 1'b1;
    vec1();
    drain();
    perf_clr = 1'b0;
    check("clr_hit_cnt", 64'(perf_hit_cnt), 64'd0);
    check("clr_miss_cnt", 64'(perf_miss_cnt), 64'd0);

    // Back-pressure: two accepted, then stalled; monitor checks stability every stalled cycle
    rsp_ready = 1'b0;
    accCnt = 0;
    vec1();
    vec2();
    fork
      begin
        vec3();
        vec4();
      end
    join_none
    repeat (3) @(posedge clk);
    #1;
    check("bp_accepted", 64'(accCnt), 64'd2);
    check("bp_req_ready", 64'(req_ready), 64'd0);
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("bp_one_per_cycle", 64'(sb.size()), 64'd1);
    @(posedge clk);
    #1;
    check("bp_all_done", 64'(sb.size()), 64'd0);
    check("bp_hit_cnt", 64'(perf_hit_cnt), 64'd2);
    check("bp_miss_cnt", 64'(perf_miss_cnt), 64'd2);

    // Reset with two requests in flight
    rsp_ready = 1'b0;
    vec5();
    vec6();
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_hit_cnt", 64'(perf_hit_cnt), 64'd0);
    check("rst_miss_cnt", 64'(perf_miss_cnt), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_fields", 64'({rsp_hit, rsp_multi_hit, rsp_hit_way, rsp_have_empty,
          rsp_victim_way, rsp_need_wb, rsp_plru_next}), 64'd0);
    sb.delete();
    #12;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    #1;
    check("rst_release_ready", 64'(req_ready), 64'd1);
    repeat (8) @(posedge clk);
    #1;
    check("no_stale_rsp", 64'(rsp_valid), 64'd0);
    vec7();
    drain();
    check("post_rst_miss_cnt", 64'(perf_miss_cnt), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/l2cache_tag_lookup.md
L2CACHE_TAG_LOOKUP -- requirements
Module: l2cache_tag_lookup

Interface
REQ-001 SHALL provide parameter WAYS, default 8, number of ways (power of 2, 2..16).
REQ-002 SHALL provide parameter TAG_W, default 19, tag width (PA[33:15] at default).
REQ-003 SHALL provide parameter CNT_W, default 32, performance counter width.
REQ-004 SHALL derive WAY_W = log2(WAYS) and PLRU_W = WAYS-1 internally.
REQ-005 SHALL have ports: clk in 1, single clock; rst_n in 1, asynchronous active-low reset.
REQ-006 SHALL have ports: req_valid in 1; req_ready out 1; req_tag in TAG_W, tag to compare.
REQ-007 SHALL have ports: req_way_tags in WAYS*TAG_W, way i at bits [i*TAG_W +: TAG_W]; req_v in WAYS, valid bits; req_d in WAYS, dirty bits; req_plru in PLRU_W, tree-PLRU state.
REQ-008 SHALL have ports: rsp_valid out 1; rsp_ready in 1; rsp_hit out 1; rsp_multi_hit out 1; rsp_hit_way out WAY_W; rsp_have_empty out 1.
REQ-009 SHALL have ports: rsp_victim_way out WAY_W; rsp_need_wb out 1; rsp_plru_next out PLRU_W.
REQ-010 SHALL have ports: perf_clr in 1; perf_hit_cnt out CNT_W; perf_miss_cnt out CNT_W.

Function
REQ-011 Way i SHALL hit when req_tag == tag_i and req_v[i] == 1, using equality, not subtraction.
REQ-012 rsp_hit SHALL be the OR of all way hits; rsp_hit_way SHALL be the lowest-index hitting way, else 0.
REQ-013 rsp_multi_hit SHALL be 1 when two or more ways hit.
REQ-014 rsp_have_empty SHALL be 1 when any req_v bit is 0; the empty way SHALL be the lowest-index invalid way.
REQ-015 The PLRU tree SHALL be heap-indexed: node 0 is the root; node n has children 2n+1 and 2n+2; leaf nodes select way pairs.
REQ-016 A PLRU node bit of 0 SHALL point to its lower-index half and 1 to its upper half; the evict way is found by following the pointers from the root.
REQ-017 rsp_victim_way SHALL be: the hit way on a hit; else the empty way if rsp_have_empty; else the PLRU evict way.
REQ-018 rsp_need_wb SHALL be 1 only when miss, not rsp_have_empty, and req_d[victim] == 1; it SHALL be 0 on a hit.
REQ-019 rsp_plru_next SHALL equal req_plru with every node on the path to rsp_victim_way set to point away from that way; all other bits SHALL be unchanged.
REQ-020 The block SHALL be a two-stage pipeline: S1 registers the request, compare logic sits between S1 and S2, and S2 holds the response registers.
REQ-021 A request SHALL be accepted on a clk edge where req_valid and req_ready are both 1.
REQ-022 rsp_valid SHALL rise after the second clk edge following acceptance (latency 2); throughput SHALL be one request per cycle when rsp_ready is 1.
REQ-023 S2 SHALL advance when !rsp_valid or rsp_ready; S1 SHALL move into S2 only when S2 advances.
REQ-024 req_ready SHALL be 1 when S1 is empty or S1 is moving into S2, i.e. combinationally dependent on rsp_ready.
REQ-025 While rsp_valid == 1 and rsp_ready == 0, all rsp_* outputs SHALL hold stable; no response SHALL be dropped, duplicated or reordered.
REQ-026 On each response handshake, perf_hit_cnt SHALL increment on a hit and perf_miss_cnt on a miss; both SHALL saturate at all-ones.
REQ-027 perf_clr SHALL zero both counters synchronously and SHALL take priority over a same-cycle increment.

Reset
REQ-028 On rst_n low, S1/S2 valid bits, rsp_valid and both counters SHALL clear to 0 immediately, regardless of clk.
REQ-029 While rst_n is low, req_ready SHALL be 0; after release, req_ready SHALL be 1 on the first cycle.
REQ-030 On reset, rsp_hit, rsp_multi_hit, rsp_have_empty, rsp_need_wb, rsp_hit_way, rsp_victim_way and rsp_plru_next SHALL all be 0.
REQ-031 An in-flight request interrupted by reset SHALL be discarded and SHALL produce no response.

Verification
REQ-032 Hit with WAYS=8, distinct tags, req_tag = tag5, req_v=8'hFF, req_d[5]=1, req_plru=7'h00 -> rsp_hit=1, hit_way=5, victim=5, need_wb=0, plru_next=7'h04, perf_hit_cnt=1.
REQ-033 Miss with empty way, req_v=8'hF7, no tag match -> hit=0, have_empty=1, victim=3, need_wb=0, plru_next=7'h01, perf_miss_cnt=1.
REQ-034 Miss with all ways full, req_v=8'hFF, req_plru=7'h12, req_d=8'h08 -> victim=3, need_wb=1, plru_next=7'h01.
REQ-035 Multi-hit and valid gating: tag1 == tag6 == req_tag with both valid -> hit_way=1, multi_hit=1; the same case with req_v[1]=0 -> hit_way=6, multi_hit=0.
REQ-036 Back-pressure: stream 4 requests with rsp_ready=0 -> req_ready falls after 2 acceptances and rsp_* stay stable; raise rsp_ready -> all 4 responses arrive in order, one per cycle.
REQ-037 Reset mid-flight: assert rst_n low between clk edges with 2 requests in flight -> rsp_valid=0 and counters=0 immediately; after release, no stale response appears.
